data_sram_resp: RTL and testbench

Data-side SRAM responder for the pipelined CPU. It answers the request/response handshake driven by the EX stage and returns read data that the MEM stage consumes on `data_sram_rdata`. Requests are accepted with `addr_ok` and answered strictly in order with a one-cycle `data_ok` pulse a fixed `LATENCY` cycles later. Up to `QUEUE` requests may be outstanding. The block serves as the synthesizable memory model for simulation and FPGA test boards.

---
 rtl/data_sram_resp.sv | 145 ++++++++++++++
 tb/tb_data_sram_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: a byte-writable word array behind a small in-order
// queue that answers every accepted request exactly LATENCY cycles later.

// One queue slot: holds the captured response and ages it toward retirement.
module data_sram_resp_ent #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        wr_i,
  input  logic [31:0] data_i,
  output logic        vld_o,
  output logic        wr_o,
  output logic [31:0] data_o,
  output logic        done_o
);
  localparam int AW = $clog2(LATENCY + 1);

  logic          vld_q, wr_q;
  logic [31:0]   data_q;
  logic [AW-1:0] age_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q  <= 1'b0;
      wr_q   <= 1'b0;
      data_q <= '0;
      age_q  <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      wr_q   <= wr_i;
      data_q <= data_i;
      age_q  <= AW'(1);
    end else if (pop_i) begin
      vld_q  <= 1'b0;
    end else if (vld_q && age_q != AW'(LATENCY)) begin
      age_q  <= age_q + 1'b1;
    end
  end

  assign vld_o  = vld_q;
  assign wr_o   = wr_q;
  assign data_o = data_q;
  assign done_o = vld_q && (age_q == AW'(LATENCY));
endmodule

module data_sram_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QUEUE      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (QUEUE > 1) ? $clog2(QUEUE) : 1;
  localparam int CW    = $clog2(QUEUE + 1);

  logic [31:0]             mem_q [DEPTH];
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DEPTH_LOG2-1:0]   widx;
  logic [31:0]             cap_word;
  logic                    acc, ret;
  logic [QUEUE-1:0]        ent_vld, ent_wr, ent_done;
  logic [QUEUE-1:0][31:0]  ent_data;
  logic                    unused_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QUEUE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Size and the sub-word/high address bits never change behaviour.
  assign unused_ok = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2],
                       data_sram_addr[1:0], ent_vld};

  assign widx     = data_sram_addr[DEPTH_LOG2+1:2];
  assign acc      = resetn && data_sram_req && (count_q < CW'(QUEUE));
  assign ret      = ent_done[head_q];
  assign cap_word = data_sram_wr ? 32'h0 : mem_q[widx];

  assign data_sram_addr_ok = acc;
  assign data_sram_data_ok = ret;
  assign data_sram_rdata   = (ret && !ent_wr[head_q]) ? ent_data[head_q] : 32'h0;

  // Array is deliberately left out of reset so accepted writes survive it.
  always_ff @(posedge clk) begin
    if (acc && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem_q[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  for (genvar g = 0; g < QUEUE; g++) begin : g_ent
    data_sram_resp_ent #(.LATENCY(LATENCY)) u_ent (
      .clk    (clk),
      .resetn (resetn),
      .load_i (acc && (tail_q == PW'(g))),
      .pop_i  (ret && (head_q == PW'(g))),
      .wr_i   (data_sram_wr),
      .data_i (cap_word),
      .vld_o  (ent_vld[g]),
      .wr_o   (ent_wr[g]),
      .data_o (ent_data[g]),
      .done_o (ent_done[g])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (acc) tail_d = nxt(tail_q);
    if (ret) head_d = nxt(head_q);
    case ({acc, ret})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench: three responder configs (Q4/L2, Q2/L4, Q1/L1) with
// hand-computed accept cycles, response cycles and read data.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  aok, dok;
  logic [31:0] rd_a, rd_b, rd_c;

  typedef struct { int c; logic [31:0] d; } rsp_t;
  rsp_t rq_a[$], rq_b[$], rq_c[$];

  int cyc = 0, n_cmp = 0, n_bad = 0, idle_bad = 0;

  data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(2), .QUEUE(4)) dut_a (
    .clk(clk), .resetn(resetn), .data_sram_req(req[0]), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]),
    .data_sram_data_ok(dok[0]), .data_sram_rdata(rd_a));

  data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(4), .QUEUE(2)) dut_b (
    .clk(clk), .resetn(resetn), .data_sram_req(req[1]), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]),
    .data_sram_data_ok(dok[1]), .data_sram_rdata(rd_b));

  data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(1), .QUEUE(1)) dut_c (
    .clk(clk), .resetn(resetn), .data_sram_req(req[2]), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[2]),
    .data_sram_data_ok(dok[2]), .data_sram_rdata(rd_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dok[0]) rq_a.push_back('{cyc, rd_a});
    if (dok[1]) rq_b.push_back('{cyc, rd_b});
    if (dok[2]) rq_c.push_back('{cyc, rd_c});
    if ((!dok[0] && rd_a != 0) || (!dok[1] && rd_b != 0) || (!dok[2] && rd_c != 0))
      idle_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Hold req for dut s until it is accepted; ac = cycle number of the accept edge.
  task automatic issue(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] st, output int ac);
    int n;
    wr = w; addr = a; wdata = d; wstrb = st;
    req = 3'b000; req[s] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!aok[s] && n < 20);
    if (!aok[s]) begin
      chk("accept_timeout", {31'h0, aok[s]}, 32'h1);
      ac = -1;
    end else begin
      @(posedge clk); #1;
      ac = cyc;
    end
  endtask

  task automatic idle(input int n);
    req = 3'b000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rsp_chk(input string tag, input int s, input int i,
                         input int ec, input logic [31:0] ed);
    rsp_t r;
    int sz;
    sz = (s == 0) ? rq_a.size() : (s == 1) ? rq_b.size() : rq_c.size();
    if (i >= sz) begin
      chk({tag, "_missing"}, sz, i + 1);
      return;
    end
    r = (s == 0) ? rq_a[i] : (s == 1) ? rq_b[i] : rq_c[i];
    chk({tag, "_cyc"}, r.c, ec);
    chk({tag, "_dat"}, r.d, ed);
  endtask

  initial begin
    int a0, a1, t;
    int a[8];
    int bp_off[8] = '{0, 1, 5, 6, 10, 11, 15, 16};
    logic [31:0] bp_dat[8] = '{0, 0, 0, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    logic [31:0] c_dat[4] = '{0, 0, 32'h11, 32'h22};

    #1 resetn = 1'b0;
    req = 3'b111;
    #11;
    chk("rst_addr_ok", aok, 3'b000);
    chk("rst_data_ok", dok, 3'b000);
    chk("rst_rdata", rd_a | rd_b | rd_c, 32'h0);
    resetn = 1'b1;
    #1;
    chk("post_rst_addr_ok", aok, 3'b111);
    chk("post_rst_data_ok", dok, 3'b000);
    idle(1);

    // Write then read the same word, L=2.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, a1);
    idle(6);
    chk("wr_rd_back2back", a1, a0 + 1);
    rsp_chk("wr_rsp", 0, 0, a0 + 1, 32'h0);
    rsp_chk("rd_rsp", 0, 1, a0 + 2, 32'hDEADBEEF);
    chk("wr_rd_count", rq_a.size(), 2);

    // Byte strobe merge.
    rq_a.delete();
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, a0);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0100, a0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, a1);
    idle(6);
    rsp_chk("bstrb_wr", 0, 1, a0 + 1, 32'h0);
    rsp_chk("bstrb_rd", 0, 2, a1 + 1, 32'h11BB3344);

    // Index wraps modulo 1024 words.
    rq_a.delete();
    issue(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, a0);
    issue(0, 1'b0, 32'h0000, 32'h0, 4'h0, a1);
    idle(6);
    rsp_chk("wrap_rd", 0, 1, a1 + 1, 32'h12345678);

    // Streaming: 8 back-to-back reads of preloaded words 0..7.
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 32'(i * 4), 32'(i), 4'hF, t);
    idle(6);
    rq_a.delete();
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, a[i]);
    idle(6);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("strm_acc%0d", i), a[i], a[0] + i);
      rsp_chk($sformatf("strm%0d", i), 0, i, a[0] + 1 + i, 32'(i));
    end
    chk("strm_count", rq_a.size(), 8);

    // Reset while three requests are in flight.
    rq_a.delete();
    issue(0, 1'b1, 32'h40, 32'h55, 4'hF, a0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, t);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, t);
    req = 3'b000;
    chk("pre_rst_data_ok", {31'h0, dok[0]}, 32'h1);
    #2 resetn = 1'b0;
    rq_a.delete();
    req = 3'b001;
    #1;
    chk("mid_rst_data_ok", {31'h0, dok[0]}, 32'h0);
    chk("mid_rst_addr_ok", {31'h0, aok[0]}, 32'h0);
    chk("mid_rst_rdata", rd_a, 32'h0);
    @(posedge clk); #3;
    req = 3'b000;
    resetn = 1'b1;
    idle(6);
    chk("no_stale_rsp", rq_a.size(), 0);
    issue(0, 1'b0, 32'h40, 32'h0, 4'h0, a0);
    idle(6);
    rsp_chk("persist_rd", 0, 0, a0 + 1, 32'h55);

    // Backpressure, Q=2 L=4: the slot freed by a retire reopens one cycle later.
    for (int i = 0; i < 8; i++)
      issue(1, i < 4 ? 1'b0 + 1'b1 : 1'b0, 32'((i % 4) * 4), 32'hA0 + 32'(i % 4), 4'hF, a[i]);
    idle(12);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_acc%0d", i), a[i], a[0] + bp_off[i]);
      rsp_chk($sformatf("bp%0d", i), 1, i, a[i] + 3, bp_dat[i]);
    end
    chk("bp_count", rq_b.size(), 8);

    // Minimum config Q=1 L=1: response in the cycle right after accept.
    for (int i = 0; i < 4; i++)
      issue(2, i < 2 ? 1'b1 : 1'b0, 32'((i % 2) * 4), 32'h11 * 32'((i % 2) + 1), 4'hF, a[i]);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q1_acc%0d", i), a[i], a[0] + 2 * i);
      rsp_chk($sformatf("q1_%0d", i), 2, i, a[i], c_dat[i]);
    end
    chk("q1_count", rq_c.size(), 4);

    chk("rdata_zero_when_idle", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
